// File: rtl/barrier_hit_queue.sv
// barrier_hit_queue: merges player/alien barrier hits into a small FIFO and emits them spaced one per damage event
module barrier_hit_queue #(
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int BARR_YSTART = 340,
  parameter int BARR_HEIGHT = 57,
  parameter int DAMAGE_GAP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             p_hit_valid,
  input  logic [10:0]      p_hit_x,
  input  logic [10:0]      p_hit_y,
  input  logic             a_hit_valid,
  input  logic [10:0]      a_hit_x,
  input  logic [10:0]      a_hit_y,
  output logic [10:0]      damage_x,
  output logic [10:0]      damage_y,
  output logic             new_damage,
  output logic [PTR_W:0]   queue_count,
  output logic [7:0]       drop_count
);
  localparam int GW = $clog2(DAMAGE_GAP + 1) + 1;
  logic [21:0]      mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [GW-1:0]    gap;
  logic             p_in, a_in, pop, p_acc, a_acc;
  logic [PTR_W:0]   free;
  logic [8:0]       drop_sum;
  always_comb begin
    p_in     = p_hit_valid && p_hit_y >= 11'(BARR_YSTART) && p_hit_y <= 11'(BARR_YSTART + BARR_HEIGHT);
    a_in     = a_hit_valid && a_hit_y >= 11'(BARR_YSTART) && a_hit_y <= 11'(BARR_YSTART + BARR_HEIGHT);
    pop      = queue_count != '0 && gap == '0;
    // a pop this cycle frees its slot for a same-cycle push
    free     = (PTR_W+1)'(DEPTH) - queue_count + (PTR_W+1)'(pop);
    p_acc    = p_in && free != '0;
    a_acc    = a_in && free > (PTR_W+1)'(p_acc);
    drop_sum = {1'b0, drop_count} + 9'(p_in && !p_acc) + 9'(a_in && !a_acc);
  end
  always_ff @(posedge clk) begin
    if (p_acc) mem[wptr] <= {p_hit_x, p_hit_y};
    if (a_acc) mem[wptr + PTR_W'(p_acc)] <= {a_hit_x, a_hit_y};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || restart) begin
      wptr        <= '0;
      rptr        <= '0;
      gap         <= '0;
      queue_count <= '0;
      drop_count  <= '0;
      new_damage  <= 1'b0;
      damage_x    <= '0;
      damage_y    <= '0;
    end else begin
      wptr        <= wptr + PTR_W'(p_acc) + PTR_W'(a_acc);
      rptr        <= rptr + PTR_W'(pop);
      queue_count <= queue_count + (PTR_W+1)'(p_acc) + (PTR_W+1)'(a_acc) - (PTR_W+1)'(pop);
      gap         <= pop ? GW'(DAMAGE_GAP) : (gap != '0 ? gap - GW'(1) : gap);
      drop_count  <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      new_damage  <= pop;
      if (pop) {damage_x, damage_y} <= mem[rptr];
    end
  end
endmodule

// File: tb/tb_barrier_hit_queue.sv
// tb_barrier_hit_queue: scoreboard bench with a per-cycle occupancy/gap model of the hit queue
module tb_barrier_hit_queue;
  localparam int DEPTH = 4;
  localparam int YS = 340, YE = 397, GAP = 2;
  logic        clk = 0, rst = 1, restart = 0;
  logic        p_hit_valid = 0, a_hit_valid = 0;
  logic [10:0] p_hit_x = 0, p_hit_y = 0, a_hit_x = 0, a_hit_y = 0;
  logic [10:0] damage_x, damage_y;
  logic        new_damage;
  logic [2:0]  queue_count;
  logic [7:0]  drop_count;
  int tests = 0, fails = 0, nstrobe = 0;
  int mcnt = 0, mgap = 0, mdrop = 0;
  logic exp_nd = 0;
  logic [21:0] sb [$];

  barrier_hit_queue dut (
    .clk(clk), .rst(rst), .restart(restart),
    .p_hit_valid(p_hit_valid), .p_hit_x(p_hit_x), .p_hit_y(p_hit_y),
    .a_hit_valid(a_hit_valid), .a_hit_x(a_hit_x), .a_hit_y(a_hit_y),
    .damage_x(damage_x), .damage_y(damage_y), .new_damage(new_damage),
    .queue_count(queue_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (new_damage !== exp_nd) begin
        fails++;
        $display("FAIL strobe_timing t=%0t new_damage=%b expected=%b", $time, new_damage, exp_nd);
      end
      if (new_damage === 1'b1) begin
        nstrobe++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected t=%0t got (%0d,%0d) expected none", $time, damage_x, damage_y);
        end else begin
          logic [21:0] e;
          e = sb.pop_front();
          if ({damage_x, damage_y} !== e) begin
            fails++;
            $display("FAIL strobe_data t=%0t got (%0d,%0d) expected (%0d,%0d)", $time, damage_x, damage_y, e[21:11], e[10:0]);
          end
        end
      end
    end
  end

  task automatic model_clear();
    mcnt = 0; mgap = 0; mdrop = 0; exp_nd = 0; sb.delete();
  endtask

  task automatic step(input logic pv, input logic [10:0] px, input logic [10:0] py,
                      input logic av, input logic [10:0] ax, input logic [10:0] ay, input logic rs);
    logic pin, ain, pop, pacc, aacc;
    int free;
    p_hit_valid = pv; p_hit_x = px; p_hit_y = py;
    a_hit_valid = av; a_hit_x = ax; a_hit_y = ay;
    restart = rs;
    pin  = pv && py >= 11'(YS) && py <= 11'(YE);
    ain  = av && ay >= 11'(YS) && ay <= 11'(YE);
    pop  = mcnt > 0 && mgap == 0;
    free = DEPTH - mcnt + int'(pop);
    pacc = pin && free >= 1;
    aacc = ain && free >= 1 + int'(pacc);
    @(posedge clk);
    if (rs) model_clear();
    else begin
      if (pacc) sb.push_back({px, py});
      if (aacc) sb.push_back({ax, ay});
      mdrop = mdrop + int'(pin && !pacc) + int'(ain && !aacc);
      if (mdrop > 255) mdrop = 255;
      mcnt = mcnt + int'(pacc) + int'(aacc) - int'(pop);
      mgap = pop ? GAP : (mgap > 0 ? mgap - 1 : 0);
      exp_nd = pop;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({damage_x, damage_y, new_damage, queue_count, drop_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got x=%0d y=%0d nd=%b qc=%0d dc=%0d expected all 0", damage_x, damage_y, new_damage, queue_count, drop_count);
    end
    rst = 0;
  endtask

  task automatic test_single();
    idle(4);
    step(1, 100, 350, 0, 0, 0, 0);
    tests++;
    if (new_damage !== 1'b0 || queue_count !== 3'd1) begin
      fails++;
      $display("FAIL single_c6 got nd=%b qc=%0d expected nd=0 qc=1", new_damage, queue_count);
    end
    idle(1);
    tests++;
    if (new_damage !== 1'b1 || damage_x !== 11'd100 || damage_y !== 11'd350 || queue_count !== 3'd0) begin
      fails++;
      $display("FAIL single_c7 got nd=%b x=%0d y=%0d qc=%0d expected nd=1 x=100 y=350 qc=0", new_damage, damage_x, damage_y, queue_count);
    end
    idle(1);
    tests++;
    if (new_damage !== 1'b0 || damage_x !== 11'd100 || damage_y !== 11'd350) begin
      fails++;
      $display("FAIL single_hold got nd=%b x=%0d y=%0d expected nd=0 x=100 y=350", new_damage, damage_x, damage_y);
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    logic [2:0] nd_seq;
    step(1, 200, 345, 1, 210, 390, 0);
    tests++;
    if (queue_count !== 3'd2) begin
      fails++;
      $display("FAIL dual_count got %0d expected 2", queue_count);
    end
    idle(1);
    tests++;
    if (new_damage !== 1'b1 || damage_x !== 11'd200 || damage_y !== 11'd345) begin
      fails++;
      $display("FAIL dual_first got nd=%b (%0d,%0d) expected nd=1 (200,345)", new_damage, damage_x, damage_y);
    end
    idle(1); nd_seq[0] = new_damage;
    idle(1); nd_seq[1] = new_damage;
    idle(1); nd_seq[2] = new_damage;
    tests++;
    if (nd_seq !== 3'b100 || damage_x !== 11'd210 || damage_y !== 11'd390) begin
      fails++;
      $display("FAIL dual_second got gap_seq=%b (%0d,%0d) expected gap_seq=100 (210,390)", nd_seq, damage_x, damage_y);
    end
    idle(6);
  endtask

  task automatic test_band_filter();
    int s0;
    s0 = nstrobe;
    step(1, 11, 339, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12, 398, 0);
    step(1, 13, 340, 0, 0, 0, 0);
    step(0, 0, 0, 1, 14, 397, 0);
    idle(10);
    tests++;
    if (nstrobe - s0 != 2 || drop_count !== 8'd0 || sb.size() != 0) begin
      fails++;
      $display("FAIL band_filter got strobes=%0d dc=%0d pending=%0d expected strobes=2 dc=0 pending=0", nstrobe - s0, drop_count, sb.size());
    end
  endtask

  task automatic test_overflow();
    int s0, peak;
    s0 = nstrobe; peak = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 11'(10 + i), 11'(350 + i), 1, 11'(20 + i), 11'(380 + i), 0);
      if (int'(queue_count) > peak) peak = int'(queue_count);
      tests++;
      if (queue_count !== 3'(mcnt) || drop_count !== 8'(mdrop)) begin
        fails++;
        $display("FAIL overflow_step%0d got qc=%0d dc=%0d expected qc=%0d dc=%0d", i, queue_count, drop_count, mcnt, mdrop);
      end
    end
    tests++;
    if (peak != 4 || drop_count !== 8'd1) begin
      fails++;
      $display("FAIL overflow_peak got peak=%0d dc=%0d expected peak=4 dc=1", peak, drop_count);
    end
    idle(20);
    tests++;
    if (nstrobe - s0 != 6 - int'(drop_count) || sb.size() != 0) begin
      fails++;
      $display("FAIL overflow_strobes got %0d expected %0d", nstrobe - s0, 6 - int'(drop_count));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      step(1, 11'(i % 500), 11'(341 + i % 50), 1, 11'(600 + i % 400), 11'(360 + i % 30), 0);
      if (i == 3) begin
        tests++;
        if (queue_count !== 3'd4) begin
          fails++;
          $display("FAIL sat_full got qc=%0d expected 4", queue_count);
        end
      end
    end
    tests++;
    if (drop_count !== 8'd255 || mdrop != 255) begin
      fails++;
      $display("FAIL saturation got dc=%0d expected 255", drop_count);
    end
    idle(20);
  endtask

  task automatic test_restart();
    step(1, 50, 350, 1, 60, 360, 0);
    step(1, 70, 370, 1, 80, 380, 0);
    tests++;
    if (queue_count !== 3'd3) begin
      fails++;
      $display("FAIL restart_fill got qc=%0d expected 3", queue_count);
    end
    step(1, 90, 350, 1, 95, 350, 1);
    tests++;
    if (queue_count !== 3'd0 || drop_count !== 8'd0 || new_damage !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear got qc=%0d dc=%0d nd=%b expected 0 0 0", queue_count, drop_count, new_damage);
    end
    idle(10);
  endtask

  task automatic test_async_reset();
    step(1, 50, 350, 1, 60, 360, 0);
    step(1, 70, 370, 1, 80, 380, 0);
    #3 rst = 1;
    #1;
    tests++;
    if ({damage_x, damage_y, new_damage, queue_count, drop_count} !== '0) begin
      fails++;
      $display("FAIL async_reset got x=%0d y=%0d nd=%b qc=%0d dc=%0d expected all 0", damage_x, damage_y, new_damage, queue_count, drop_count);
    end
    model_clear();
    p_hit_valid = 0; a_hit_valid = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    idle(10);
    tests++;
    if (queue_count !== 3'd0 || damage_x !== 11'd0) begin
      fails++;
      $display("FAIL async_after got qc=%0d x=%0d expected 0 0", queue_count, damage_x);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_band_filter();
    test_overflow();
    test_saturation();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
